// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// widths, default halt encoding and the queue entry layout.
package fetch_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 16'hFFFF;
    localparam logic [1:0]         QUEUE_DEPTH   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of {pc, instr}. entry0 is always the head, so
// the head outputs need no read pointer. Head outputs read as zero when empty.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [1:0]         count,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    fetch_entry_t new_entry;
    logic [1:0]   count_q;

    assign new_entry = '{pc: push_pc, instr: push_instr};

    // Shift-style storage: a pop moves entry1 into the head slot.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count_q <= 2'd0;
            entry0  <= '0;
            entry1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0  <= new_entry;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        entry1  <= new_entry;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q != 2'd0) begin
                        entry0  <= entry1;
                        count_q <= count_q - 2'd1;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0 <= new_entry;
                    end else if (count_q == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = count_q;
    assign head_pc    = (count_q != 2'd0) ? entry0.pc    : '0;
    assign head_instr = (count_q != 2'd0) ? entry0.instr : '0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through the instruction store,
// buffers fetched words in a 2-entry queue and stops on the halt encoding.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; redirect only reloads the PC
//   ST_RUN  | fetching one word per cycle while the queue has room
//   ST_HALT | halt word was queued; fetch stopped until a redirect
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 10'd0,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       fetch_count_q;
    logic              halted_q;
    logic [1:0]        q_count;
    logic              pop;
    logic              push;

    // Redirect suppresses both queue ports; the queue is flushed instead.
    assign out_valid = (q_count != 2'd0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = (state == ST_RUN) && !redirect_valid &&
                       ((q_count < QUEUE_DEPTH) || pop);

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_pc    (pc),
        .push_instr (imem_rdata),
        .count      (q_count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

    // State, PC, fetch counter and halted flag; redirect outranks everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            fetch_count_q <= 16'd0;
            halted_q      <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            halted_q <= 1'b0;
            if (state != ST_IDLE) begin
                state <= ST_RUN;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        pc            <= pc + 10'd1;
                        fetch_count_q <= sat_inc16(fetch_count_q);
                        if (imem_rdata == HALT_WORD) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: ;
                default: begin
                    state    <= ST_IDLE;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_instr_fetch_ctrl;

    localparam logic [9:0]  RESET_PC  = 10'd0;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [9:0]  out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: 0 idle, 1 run, 2 halt
    int          m_mode;
    int          m_pc;
    int          m_fc;
    logic [25:0] m_q[$];

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    instr_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .HALT_WORD (HALT_WORD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic s, input logic rdy, input logic rv,
                                input logic [9:0] rp, input logic rs);
        bit          do_pop;
        bit          do_push;
        logic [15:0] w;
        if (!rs) begin
            m_mode = 0;
            m_pc   = int'(RESET_PC);
            m_q.delete();
            m_fc   = 0;
        end else if (rv) begin
            m_q.delete();
            m_pc = int'(rp);
            if (m_mode != 0) m_mode = 1;
        end else begin
            do_pop  = (m_q.size() > 0) && rdy;
            do_push = (m_mode == 1) && ((m_q.size() < 2) || do_pop);
            w       = mem[m_pc];
            if (m_mode == 0 && s) m_mode = 1;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back({10'(m_pc), w});
                m_pc = (m_pc + 1) % 1024;
                if (m_fc < 65535) m_fc++;
                if (w == HALT_WORD) m_mode = 2;
            end
        end
    endtask

    task automatic compare_model();
        logic [25:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 26'd0;
        check_val("out_valid",   {31'd0, out_valid},  {31'd0, m_q.size() > 0});
        check_val("out_instr",   {16'd0, out_instr},  {16'd0, head[15:0]});
        check_val("out_pc",      {22'd0, out_pc},     {22'd0, head[25:16]});
        check_val("imem_addr",   {22'd0, imem_addr},  32'(m_pc));
        check_val("halted",      {31'd0, halted},     {31'd0, m_mode == 2});
        check_val("fetch_count", {16'd0, fetch_count}, 32'(m_fc));
    endtask

    // One clock: drive at negedge, advance model at the edge, compare #1 later.
    task automatic step(input logic s, input logic rdy, input logic rv,
                        input logic [9:0] rp, input logic rs);
        @(negedge clk);
        start          = s;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        reset          = rs;
        @(posedge clk);
        model_update(s, rdy, rv, rp, rs);
        #1;
        compare_model();
    endtask

    initial begin
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h1111;
        exp_seq[1] = 16'h2222;
        exp_seq[2] = 16'h3333;
        exp_seq[3] = 16'hFFFF;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0100 + 16'(i);
        for (int i = 0; i < 4; i++) mem[i] = exp_seq[i];

        start = 0; out_ready = 0; redirect_valid = 0; redirect_pc = '0; reset = 0;
        m_mode = 0; m_pc = int'(RESET_PC); m_fc = 0;

        // reset state
        step(0, 0, 0, 10'd0, 0);
        step(0, 0, 0, 10'd0, 0);
        check_val("rst_addr",  {22'd0, imem_addr}, 32'h0);
        check_val("rst_valid", {31'd0, out_valid}, 32'h0);
        check_val("rst_halt",  {31'd0, halted}, 32'h0);
        check_val("rst_instr", {16'd0, out_instr}, 32'h0);

        // start cycle performs no fetch
        step(1, 1, 0, 10'd0, 1);
        check_val("start_nofetch", {31'd0, out_valid}, 32'h0);

        // straight-line program ending in the halt word
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 10'd0, 1);
            check_val("seq_instr", {16'd0, out_instr}, {16'd0, exp_seq[i]});
            check_val("seq_pc",    {22'd0, out_pc}, 32'(i));
        end
        check_val("seq_halted", {31'd0, halted}, 32'h1);
        check_val("seq_count",  {16'd0, fetch_count}, 32'd4);
        step(0, 1, 0, 10'd0, 1);

        // redirect out of HALT
        step(0, 1, 1, 10'd8, 1);
        check_val("unhalt_halted", {31'd0, halted}, 32'h0);
        check_val("unhalt_addr",   {22'd0, imem_addr}, 32'd8);
        step(0, 1, 0, 10'd0, 1);
        check_val("unhalt_pc",    {22'd0, out_pc}, 32'd8);
        check_val("unhalt_instr", {16'd0, out_instr}, 32'h0108);

        // back-pressure: queue fills, PC stalls
        step(0, 0, 0, 10'd0, 0);
        step(1, 0, 0, 10'd0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 10'd0, 1);
            check_val("stall_head", {16'd0, out_instr}, 32'h1111);
        end
        check_val("stall_addr",  {22'd0, imem_addr}, 32'd2);
        check_val("stall_count", {16'd0, fetch_count}, 32'd2);
        step(0, 1, 0, 10'd0, 1);
        check_val("stall_release", {16'd0, out_instr}, 32'h2222);

        // redirect with full queue
        step(0, 0, 1, 10'd512, 1);
        check_val("redir_valid", {31'd0, out_valid}, 32'h0);
        check_val("redir_addr",  {22'd0, imem_addr}, 32'd512);
        step(0, 0, 0, 10'd0, 1);
        check_val("redir_pc",    {22'd0, out_pc}, 32'd512);
        check_val("redir_instr", {16'd0, out_instr}, 32'h0300);

        // PC wrap 1023 -> 0
        step(0, 0, 1, 10'd1023, 1);
        step(0, 1, 0, 10'd0, 1);
        check_val("wrap_addr", {22'd0, imem_addr}, 32'd0);
        check_val("wrap_pc",   {22'd0, out_pc}, 32'd1023);

        // reset mid-RUN with full queue
        step(0, 0, 0, 10'd0, 1);
        step(0, 0, 0, 10'd0, 0);
        check_val("midrst_valid", {31'd0, out_valid}, 32'h0);
        check_val("midrst_count", {16'd0, fetch_count}, 32'h0);
        check_val("midrst_addr",  {22'd0, imem_addr}, 32'(RESET_PC));

        // fetch_count saturation with no halt word anywhere
        mem[3] = 16'h4444;
        step(1, 1, 0, 10'd0, 1);
        for (int i = 0; i < 65540; i++) step(0, 1, 0, 10'd0, 1);
        check_val("sat_count", {16'd0, fetch_count}, 32'hFFFF);

        // randomized traffic
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? HALT_WORD : 16'($urandom);
        step(0, 0, 0, 10'd0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0,
                 10'($urandom),
                 $urandom_range(0, 63) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
